blk_com_fifo_wr_arb: RTL and testbench

BLK_COM_FIFO_WR_ARB -- requirements
Module: blk_com_fifo_wr_arb

---
 rtl/blk_com_fifo_wr_arb_pkg.sv | 14 +
 rtl/blk_com_fifo_wr_arb.sv | 97 +++++++++
 tb/tb_blk_com_fifo_wr_arb.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/blk_com_fifo_wr_arb_pkg.sv
// Shared constants and arbiter state encoding for the two-channel FIFO write arbiter.
package blk_com_fifo_wr_arb_pkg;

  localparam int FIFO_DEPTH = 512;
  localparam int DATA_W     = 33;
  localparam int EOP_BIT    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/blk_com_fifo_wr_arb.sv
// Packet-granular round-robin arbiter feeding two 33-bit channels into one shared 512x33 FIFO.
// A grant needs room for a maximum-size packet; words inside a granted packet are flow-controlled on near-full.
module blk_com_fifo_wr_arb
  import blk_com_fifo_wr_arb_pkg::*;
#(
  parameter int MAX_PKT_WORDS = 64,
  parameter int CNT_W         = 16
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [DATA_W-1:0] I_ch0_din,
  input  logic              I_ch0_vld,
  output logic              O_ch0_rdy,
  input  logic [DATA_W-1:0] I_ch1_din,
  input  logic              I_ch1_vld,
  output logic              O_ch1_rdy,
  output logic [DATA_W-1:0] O_fifo_din,
  output logic              O_fifo_wr,
  input  logic [9:0]        I_fifo_usedw,
  output logic [CNT_W-1:0]  O_ch0_pkt_cnt,
  output logic [CNT_W-1:0]  O_ch1_pkt_cnt,
  output logic [1:0]        O_grant
);

  localparam logic [10:0] START_LIMIT = 11'(FIFO_DEPTH - MAX_PKT_WORDS);
  localparam logic [10:0] HOLD_LIMIT  = 11'(FIFO_DEPTH - 1);

  arb_state_t  state;
  logic        last_ch1;
  logic        armed;
  logic [10:0] level;
  logic        space_ok;
  logic        room_ok;
  logic        xfer0;
  logic        xfer1;
  logic        eop0;
  logic        eop1;

  // The word written last cycle is not yet in usedw, so it is added back in.
  assign level    = {1'b0, I_fifo_usedw} + 11'(O_fifo_wr);
  assign space_ok = (level <= START_LIMIT);
  assign room_ok  = (level < HOLD_LIMIT) && !I_fifo_usedw[9];

  assign O_ch0_rdy = (state == OWN0) && room_ok;
  assign O_ch1_rdy = (state == OWN1) && room_ok;
  assign O_grant   = {state == OWN1, state == OWN0};

  assign xfer0 = I_ch0_vld && O_ch0_rdy;
  assign xfer1 = I_ch1_vld && O_ch1_rdy;
  assign eop0  = xfer0 && I_ch0_din[EOP_BIT];
  assign eop1  = xfer1 && I_ch1_din[EOP_BIT];

  // armed delays the first grant by one edge after reset is released.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state         <= IDLE;
      last_ch1      <= 1'b1;
      armed         <= 1'b0;
      O_fifo_wr     <= 1'b0;
      O_fifo_din    <= '0;
      O_ch0_pkt_cnt <= '0;
      O_ch1_pkt_cnt <= '0;
    end else begin
      armed     <= 1'b1;
      O_fifo_wr <= xfer0 || xfer1;
      if (xfer0) begin
        O_fifo_din <= I_ch0_din;
      end else if (xfer1) begin
        O_fifo_din <= I_ch1_din;
      end
      if (eop0) begin
        O_ch0_pkt_cnt <= O_ch0_pkt_cnt + CNT_W'(1);
      end
      if (eop1) begin
        O_ch1_pkt_cnt <= O_ch1_pkt_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (armed && space_ok) begin
            if (I_ch0_vld && (!I_ch1_vld || last_ch1)) begin
              state    <= OWN0;
              last_ch1 <= 1'b0;
            end else if (I_ch1_vld) begin
              state    <= OWN1;
              last_ch1 <= 1'b1;
            end
          end
        end
        OWN0: if (eop0) state <= IDLE;
        OWN1: if (eop1) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blk_com_fifo_wr_arb.sv
// Directed bench for the FIFO write arbiter: single packet, contention, space gate, near-full, reset, counter wrap.
module tb_blk_com_fifo_wr_arb;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic [32:0] I_ch0_din;
  logic        I_ch0_vld;
  logic        O_ch0_rdy;
  logic [32:0] I_ch1_din;
  logic        I_ch1_vld;
  logic        O_ch1_rdy;
  logic [32:0] O_fifo_din;
  logic        O_fifo_wr;
  logic [9:0]  I_fifo_usedw;
  logic [3:0]  O_ch0_pkt_cnt;
  logic [3:0]  O_ch1_pkt_cnt;
  logic [1:0]  O_grant;

  int vec_cnt = 0;
  int err_cnt = 0;

  blk_com_fifo_wr_arb #(.MAX_PKT_WORDS(64), .CNT_W(4)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_ch0_din(I_ch0_din), .I_ch0_vld(I_ch0_vld), .O_ch0_rdy(O_ch0_rdy),
    .I_ch1_din(I_ch1_din), .I_ch1_vld(I_ch1_vld), .O_ch1_rdy(O_ch1_rdy),
    .O_fifo_din(O_fifo_din), .O_fifo_wr(O_fifo_wr), .I_fifo_usedw(I_fifo_usedw),
    .O_ch0_pkt_cnt(O_ch0_pkt_cnt), .O_ch1_pkt_cnt(O_ch1_pkt_cnt), .O_grant(O_grant)
  );

  always #5 I_clk = ~I_clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic do_reset();
    I_rst_n      = 1'b0;
    I_ch0_vld    = 1'b0;
    I_ch1_vld    = 1'b0;
    I_ch0_din    = '0;
    I_ch1_din    = '0;
    I_fifo_usedw = '0;
    tick();
    tick();
    I_rst_n = 1'b1;
  endtask

  // Sends n words on one channel, EOP on the last, checking each registered write.
  task automatic applyStimulus(input int ch, input int n, input logic [31:0] base, input string tag);
    logic [32:0] w;
    int waits;
    for (int i = 0; i < n; i++) begin
      w = {(i == n - 1), base + 32'(i)};
      if (ch == 0) begin I_ch0_din = w; I_ch0_vld = 1'b1; end
      else         begin I_ch1_din = w; I_ch1_vld = 1'b1; end
      #1;
      waits = 0;
      while (((ch == 0) ? O_ch0_rdy : O_ch1_rdy) == 1'b0 && waits < 50) begin
        tick();
        waits++;
      end
      if (waits == 50) begin
        checkOutput({tag, "_rdy_timeout"}, 64'd0, 64'd1);
        I_ch0_vld = 1'b0;
        I_ch1_vld = 1'b0;
        return;
      end
      tick();
      checkOutput({tag, "_wr"}, 64'(O_fifo_wr), 64'd1);
      checkOutput({tag, "_din"}, 64'(O_fifo_din), 64'(w));
    end
    I_ch0_vld = 1'b0;
    I_ch1_vld = 1'b0;
  endtask

  function automatic logic [32:0] cont_word(input int ch, input int idx);
    logic [31:0] base;
    base = (ch == 0) ? 32'hA000_0000 : 32'hB000_0000;
    return {((idx % 3) == 2), base + 32'(idx)};
  endfunction

  initial begin
    int idx0, idx1, nwr, cyc, blk;
    logic t0, t1;
    logic [32:0] expw;

    // Single channel packet after reset
    do_reset();
    checkOutput("rst_wr", 64'(O_fifo_wr), 64'd0);
    checkOutput("rst_grant", 64'(O_grant), 64'd0);
    checkOutput("rst_rdy", 64'({O_ch0_rdy, O_ch1_rdy}), 64'd0);
    checkOutput("rst_cnt", 64'({O_ch0_pkt_cnt, O_ch1_pkt_cnt}), 64'd0);
    I_ch0_vld = 1'b1;
    I_ch0_din = {1'b0, 32'h1234_0000};
    tick();
    checkOutput("grant_edge1", 64'(O_grant), 64'd0);
    tick();
    checkOutput("grant_edge2", 64'(O_grant), 64'd1);
    checkOutput("rdy0_owned", 64'(O_ch0_rdy), 64'd1);
    applyStimulus(0, 4, 32'h1234_0000, "single");
    checkOutput("single_cnt0", 64'(O_ch0_pkt_cnt), 64'd1);
    checkOutput("single_idle", 64'(O_grant), 64'd0);
    tick();
    checkOutput("single_wr_off", 64'(O_fifo_wr), 64'd0);

    // Contention: both channels stream 3-word packets
    do_reset();
    I_ch0_vld = 1'b1;
    I_ch1_vld = 1'b1;
    idx0 = 0; idx1 = 0; nwr = 0; cyc = 0;
    while (nwr < 12 && cyc < 100) begin
      I_ch0_din = cont_word(0, idx0);
      I_ch1_din = cont_word(1, idx1);
      #1;
      t0 = O_ch0_rdy;
      t1 = O_ch1_rdy;
      tick();
      cyc++;
      if (t0) idx0++;
      if (t1) idx1++;
      if (O_fifo_wr) begin
        blk  = nwr / 3;
        expw = cont_word(blk % 2, (blk / 2) * 3 + (nwr % 3));
        checkOutput("cont_word", 64'(O_fifo_din), 64'(expw));
        nwr++;
      end
    end
    checkOutput("cont_nwords", 64'(nwr), 64'd12);
    checkOutput("cont_cnt0", 64'(O_ch0_pkt_cnt), 64'd2);
    checkOutput("cont_cnt1", 64'(O_ch1_pkt_cnt), 64'd2);

    // Space gate, then near-full flow control in OWN0
    do_reset();
    I_fifo_usedw = 10'd449;
    I_ch0_vld = 1'b1;
    I_ch0_din = {1'b0, 32'hC0DE_0000};
    repeat (4) tick();
    checkOutput("gate_449_grant", 64'(O_grant), 64'd0);
    checkOutput("gate_449_rdy", 64'(O_ch0_rdy), 64'd0);
    I_fifo_usedw = 10'd448;
    tick();
    checkOutput("gate_448_grant", 64'(O_grant), 64'd1);
    I_fifo_usedw = 10'd509;
    #1;
    checkOutput("nf_509_rdy", 64'(O_ch0_rdy), 64'd1);
    tick();
    checkOutput("nf_509_wr", 64'(O_fifo_wr), 64'd1);
    I_fifo_usedw = 10'd510;
    #1;
    checkOutput("nf_510_wr1_rdy", 64'(O_ch0_rdy), 64'd0);
    tick();
    checkOutput("nf_510_wr", 64'(O_fifo_wr), 64'd0);
    checkOutput("nf_510_wr0_rdy", 64'(O_ch0_rdy), 64'd1);
    I_fifo_usedw = 10'h205;
    #1;
    checkOutput("nf_full_rdy", 64'({O_ch0_rdy, O_ch1_rdy}), 64'd0);
    tick();
    checkOutput("nf_full_wr", 64'(O_fifo_wr), 64'd0);
    checkOutput("nf_full_grant", 64'(O_grant), 64'd1);

    // Reset in the middle of a 5-word packet
    do_reset();
    applyStimulus(0, 1, 32'hD000_0000, "pre");
    checkOutput("pre_cnt0", 64'(O_ch0_pkt_cnt), 64'd1);
    I_ch0_vld = 1'b1;
    I_ch0_din = {1'b0, 32'hE000_0000};
    tick();
    tick();
    checkOutput("mid_w0_rdy", 64'(O_ch0_rdy), 64'd1);
    tick();
    I_ch0_din = {1'b0, 32'hE000_0001};
    tick();
    I_ch0_din = {1'b0, 32'hE000_0002};
    I_rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_wr", 64'(O_fifo_wr), 64'd0);
    checkOutput("mid_rst_din", 64'(O_fifo_din), 64'd0);
    checkOutput("mid_rst_grant", 64'(O_grant), 64'd0);
    checkOutput("mid_rst_cnt0", 64'(O_ch0_pkt_cnt), 64'd0);
    I_rst_n = 1'b1;
    I_ch0_vld = 1'b0;
    I_ch1_vld = 1'b1;
    I_ch1_din = {1'b0, 32'hF000_0000};
    tick();
    checkOutput("post_edge1_grant", 64'(O_grant), 64'd0);
    tick();
    checkOutput("post_edge2_grant", 64'(O_grant), 64'd2);
    applyStimulus(1, 2, 32'hF000_0000, "post");
    checkOutput("post_cnt1", 64'(O_ch1_pkt_cnt), 64'd1);

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int p = 0; p < 17; p++) begin
      applyStimulus(1, 1, 32'h5500_0000 + 32'(p), "wrap");
    end
    checkOutput("wrap_cnt1", 64'(O_ch1_pkt_cnt), 64'd1);
    checkOutput("wrap_cnt0", 64'(O_ch0_pkt_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
